eeprom_burst_seq: RTL and testbench
===================================

# eeprom_burst_seq

Command sequencer that sits directly upstream of the EEPROM byte read/write controller, in place of the testbench stimulus generator. It accepts burst commands of 1–16 bytes from a host. It breaks each burst into single-byte `wr`/`rd` requests on the controller's `addr`/`data` interface and waits for `ack` on each. It enforces a programmable inter-byte gap for the EEPROM write cycle, returns read bytes, and aborts on an `ack` timeout.

## Interface
Parameters:
- `GAP_CYCLES`, 16: idle cycles inserted after each `ack` before the next byte request (minimum 1).
- `TIMEOUT_CYCLES`, 4096: maximum cycles spent waiting for `ack` before the burst is aborted.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  host command strobe.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_op`  in  1  0 = write, 1 = read.
- `cmd_addr`  in  11  start byte address.
- `cmd_len`  in  4  byte count minus 1 (1..16 bytes).
- `wdata_valid`  in  1  host write byte available.
- `wdata_ready`  out  1  block takes the write byte this cycle.
- `wdata`  in  8  host write byte.
- `rdata_valid`  out  1  one-cycle pulse; no backpressure.
- `rdata`  out  8  read byte, valid with `rdata_valid`.
- `done`  out  1  one-cycle pulse at burst end.
- `err`  out  1  high together with `done` when the burst was aborted by timeout.
- `busy`  out  1  high in any state except IDLE.
- `wr`  out  1  byte-write request to the EEPROM controller.
- `rd`  out  1  byte-read request to the EEPROM controller.
- `addr`  out  11  byte address for the current request.
- `data_out`  out  8  write byte driven toward the controller.
- `data_oe`  out  1  enables the top-level tristate on `data` during writes.
- `data_in`  in  8  `data` bus as seen by this block.
- `ack`  in  1  controller completion pulse.

## Operation
- FSM states: IDLE, FETCH, ISSUE, WAIT_ACK, GAP, DONE.
- IDLE:
  - On `cmd_valid` with `cmd_ready`, latch `op`, `addr`, and `remaining = cmd_len`.
  - Go to FETCH for a write, ISSUE for a read.
- FETCH (write only):
  - `wdata_ready` is 1.
  - On `wdata_valid`, capture `wdata` into the byte register and go to ISSUE.
  - Waits indefinitely; no timeout applies here.
- ISSUE:
  - Register `wr` or `rd` high.
  - Drive `addr`.
  - For a write, drive `data_out` and set `data_oe`.
  - Go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK:
  - `wr`/`rd`, `addr`, `data_out` and `data_oe` are held stable.
  - On `ack` = 1:
    - Drop `wr`/`rd`/`data_oe` on the next edge.
    - For a read, capture `data_in` on the `ack` cycle.
    - Go to GAP.
  - If the counter reaches `TIMEOUT_CYCLES`:
    - Drop requests.
    - Go to DONE with `err` set.
    - Remaining bytes are discarded; no further `wdata` is taken.
- GAP:
  - Count `GAP_CYCLES`.
  - Then, if `remaining` == 0, go to DONE.
  - Otherwise decrement `remaining`, increment `addr` modulo 2048 (0x7FF wraps to 0x000), and go to FETCH or ISSUE.
- DONE: pulse `done` (and `err` if the burst aborted), then return to IDLE.
- `ack` arriving outside WAIT_ACK is ignored.
- `wr` and `rd` are never high simultaneously.
- Reset values:
  - All outputs are 0: `cmd_ready`, `wdata_ready`, `rdata_valid`, `rdata`, `done`, `err`, `busy`, `wr`, `rd`, `addr`, `data_out`, `data_oe`.
  - `cmd_ready` rises on the first clock after reset release.
- Reset asserted mid-burst clears `wr`/`rd`/`data_oe` immediately (asynchronously). No `done` is generated for the lost burst.

## Timing
- Command accept edge to `wr`/`rd` high:
  - Read: 2 cycles (IDLE→ISSUE→WAIT_ACK; request registered in ISSUE).
  - Write: 2 cycles plus FETCH wait (≥3 cycles).
- `ack` cycle N:
  - `wr`/`rd` low at N+1.
  - `rdata_valid` pulse at N+1 carries the byte sampled at N.
- The next byte request rises at N+1+`GAP_CYCLES`+1 for reads; for writes, add the FETCH wait.
- `done` rises 1 cycle after the last GAP ends; `cmd_ready` rises the cycle after `done`.
- Timeout: with the request high from cycle T, `err`/`done` pulse at T+`TIMEOUT_CYCLES`+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared definitions file `eeprom_defs`:
  - `ADDR_W` = 11, `DATA_W` = 8.
  - Op encoding `OP_WR` = 0, `OP_RD` = 1.
  - FSM state encodings.
  - Used by this block, the EEPROM controller and the bench.
- One sub-module, `eeprom_wait_cnt`: a loadable down-counter with a terminal flag, instanced twice (gap and timeout).
- The FSM and the address/length datapath stay in the top module.

## Test plan
- Single write:
  - Stimulus: op = 0, addr = 0x123, len = 0, wdata = 0xA5, `ack` after 50 cycles.
  - Response: one `wr` pulse with addr 0x123 and `data_out` 0xA5; `done` = 1, `err` = 0.
- Read burst:
  - Stimulus: op = 1, addr = 0x010, len = 3; model returns 0x11, 0x22, 0x33, 0x44.
  - Response: four `rdata_valid` pulses in that order; addresses 0x010–0x013; each `rd` starts ≥`GAP_CYCLES` after the prior `ack`.
- Wrap-around:
  - Stimulus: write burst, addr = 0x7FE, len = 3.
  - Response: addresses 0x7FE, 0x7FF, 0x000, 0x001.
- Timeout:
  - Stimulus: read with `ack` never asserted.
  - Response: `rd` drops and `done` = `err` = 1 at `TIMEOUT_CYCLES`+1; no `rdata_valid`; the next command is accepted.
- Write starvation, stray `ack`, mid-burst reset:
  - Stimulus: hold `wdata_valid` low for 500 cycles; pulse `ack` in IDLE/GAP; assert `reset` mid WAIT_ACK.
  - Response: no `wr` until data arrives and no timeout fires; stray `ack` has no effect; all outputs reach 0 within the reset cycle and there is no `done`.

Source files
------------

// File: rtl/eeprom_defs.sv
// Shared definitions for the EEPROM burst sequencer, the byte controller and benches.
package eeprom_defs;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_ACK,
    S_GAP,
    S_DONE
  } seq_state_e;

  // Byte addresses wrap from the top of the array back to zero.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction
endpackage

// File: rtl/eeprom_wait_cnt.sv
// Loadable down-counter that parks at zero; zero_o flags the terminal count.
module eeprom_wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/eeprom_burst_seq.sv
// Splits host bursts of 1-16 bytes into single-byte wr/rd requests toward the
// EEPROM byte controller, with an inter-byte gap and an ack timeout.
module eeprom_burst_seq
  import eeprom_defs::*;
#(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              wr,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ack
);
  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // GAP state lasts exactly GAP_CYCLES cycles; WAIT_ACK gives up once TIMEOUT_CYCLES have elapsed.
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES);

  seq_state_e        state_q, state_d;
  logic              op_q;
  logic [3:0]        remain_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wbyte_q, data_out_q, rdata_q;
  logic              cmd_ready_q, wdata_ready_q, rdata_valid_q, done_q, err_q, busy_q;
  logic              wr_q, rd_q, data_oe_q;
  logic              gap_load, gap_en, gap_zero;
  logic              to_load, to_en, to_zero;

  assign gap_load = (state_q == S_WAIT_ACK) && ack;
  assign gap_en   = (state_q == S_GAP);
  assign to_load  = (state_q == S_ISSUE);
  assign to_en    = (state_q == S_WAIT_ACK);

  eeprom_wait_cnt #(.W(CNT_W)) u_gap_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (gap_load),
    .load_val_i (GAP_LOAD),
    .en_i       (gap_en),
    .zero_o     (gap_zero)
  );

  eeprom_wait_cnt #(.W(CNT_W)) u_to_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (to_load),
    .load_val_i (TO_LOAD),
    .en_i       (to_en),
    .zero_o     (to_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (cmd_valid && cmd_ready_q) state_d = (cmd_op == OP_RD) ? S_ISSUE : S_FETCH;
      S_FETCH:    if (wdata_valid && wdata_ready_q) state_d = S_ISSUE;
      S_ISSUE:    state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (ack)          state_d = S_GAP;
        else if (to_zero) state_d = S_DONE;
      end
      S_GAP: begin
        if (gap_zero) begin
          if (remain_q == 4'd0) state_d = S_DONE;
          else                  state_d = (op_q == OP_RD) ? S_ISSUE : S_FETCH;
        end
      end
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= OP_WR;
      remain_q      <= '0;
      addr_q        <= '0;
      wbyte_q       <= '0;
      data_out_q    <= '0;
      rdata_q       <= '0;
      cmd_ready_q   <= 1'b0;
      wdata_ready_q <= 1'b0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      data_oe_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= (state_d == S_IDLE);
      busy_q        <= (state_d != S_IDLE);
      wdata_ready_q <= (state_d == S_FETCH);
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (state_d != S_IDLE) begin
            op_q     <= cmd_op;
            addr_q   <= cmd_addr;
            remain_q <= cmd_len;
          end
        end
        S_FETCH: begin
          if (state_d == S_ISSUE) wbyte_q <= wdata;
        end
        S_ISSUE: begin
          wr_q      <= (op_q == OP_WR);
          rd_q      <= (op_q == OP_RD);
          data_oe_q <= (op_q == OP_WR);
          if (op_q == OP_WR) data_out_q <= wbyte_q;
        end
        S_WAIT_ACK: begin
          if (state_d != S_WAIT_ACK) begin
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            data_oe_q <= 1'b0;
            if (ack) begin
              if (op_q == OP_RD) begin
                rdata_q       <= data_in;
                rdata_valid_q <= 1'b1;
              end
            end else begin
              // Timed out: the rest of the burst is dropped.
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_zero) begin
            if (remain_q == 4'd0) begin
              done_q <= 1'b1;
            end else begin
              remain_q <= remain_q - 4'd1;
              addr_q   <= next_addr(addr_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign wr          = wr_q;
  assign rd          = rd_q;
  assign addr        = addr_q;
  assign data_out    = data_out_q;
  assign data_oe     = data_oe_q;
endmodule

// File: tb/tb_eeprom_burst_seq.sv
// Directed bench for eeprom_burst_seq: EEPROM controller model, write-data feeder
// and a scoreboard of expected requests, read bytes and burst completions.
module tb_eeprom_burst_seq;
  import eeprom_defs::*;

  localparam int GAP = 16;
  localparam int TO  = 200;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_op = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [3:0]        cmd_len = '0;
  logic              wdata_valid = 1'b0;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata = '0;
  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              done, err, busy, wr, rd, data_oe;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in = '0;
  logic              model_ack = 1'b0;
  logic              stray_ack = 1'b0;
  logic              ack;

  assign ack = model_ack | stray_ack;

  eeprom_burst_seq #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .wr          (wr),
    .rd          (rd),
    .addr        (addr),
    .data_out    (data_out),
    .data_oe     (data_oe),
    .data_in     (data_in),
    .ack         (ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t              exp_req_q[$];
  logic [DATA_W-1:0] exp_rd_q[$];
  logic              exp_done_q[$];
  logic [DATA_W-1:0] wdata_q[$];
  logic [DATA_W-1:0] eeprom [0:2047];
  logic [DATA_W-1:0] shadow [0:2047];
  logic [DATA_W-1:0] wbuf [0:15];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int req_rises = 0;
  int done_cnt = 0;
  int ack_delay = 1;
  bit ack_en = 1'b1;
  bit wd_hold = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  always @(posedge clk) cyc++;

  // EEPROM byte controller model: acks a held request after ack_delay cycles.
  int wait_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      model_ack = 1'b0;
      wait_cnt  = 0;
    end else if (model_ack) begin
      model_ack = 1'b0;
      wait_cnt  = 0;
    end else if ((wr || rd) && ack_en) begin
      wait_cnt++;
      if (wait_cnt >= ack_delay) begin
        model_ack = 1'b1;
        if (wr) eeprom[addr] = data_out;
        else    data_in = eeprom[addr];
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Host write-data feeder.
  bit                wd_fire = 1'b0;
  logic [DATA_W-1:0] wd_tmp;
  always @(negedge clk) begin
    if (wd_fire && wdata_q.size() != 0) wd_tmp = wdata_q.pop_front();
    wdata_valid = !wd_hold && (wdata_q.size() != 0);
    wdata       = wdata_valid ? wdata_q[0] : 8'h00;
    wd_fire     = wdata_valid && wdata_ready;
  end

  // Output monitor / scoreboard, sampled mid-cycle.
  bit                req_prev = 1'b0, ack_prev = 1'b0, have_ack = 1'b0, req_now;
  int                last_ack_cyc = 0, req_rise_cyc = 0;
  req_t              m_e;
  logic [DATA_W-1:0] m_d;
  logic              m_err;
  always @(negedge clk) begin
    #1;
    if (reset) begin
      req_prev = 1'b0;
      ack_prev = 1'b0;
      have_ack = 1'b0;
    end else begin
      req_now = wr || rd;
      if (req_now && !req_prev) begin
        req_rises++;
        $display("req  cyc=%0d op=%0d addr=%03h data_out=%02h", cyc, rd, addr, data_out);
        chk("wr_rd_exclusive", 64'(wr && rd), 64'(0));
        chk("req_expected", 64'(exp_req_q.size() != 0), 64'(1));
        if (exp_req_q.size() != 0) begin
          m_e = exp_req_q.pop_front();
          chk("req_op", 64'(rd), 64'(m_e.op));
          chk("req_addr", 64'(addr), 64'(m_e.addr));
          if (m_e.op == OP_WR) chk("wr_data_oe", 64'({data_oe, data_out}), 64'({1'b1, m_e.data}));
          else                 chk("rd_no_oe", 64'(data_oe), 64'(0));
          if (have_ack) begin
            if (m_e.op == OP_RD) chk("rd_gap", 64'(cyc - last_ack_cyc), 64'(GAP + 2));
            else                 chk("wr_gap_min", 64'(cyc - last_ack_cyc >= GAP + 3), 64'(1));
          end
        end
        req_rise_cyc = cyc;
      end
      if (req_prev && ack_prev) chk("req_drop_after_ack", 64'({wr, rd, data_oe}), 64'(0));
      if (rdata_valid) begin
        $display("rdat cyc=%0d rdata=%02h", cyc, rdata);
        chk("rdata_expected", 64'(exp_rd_q.size() != 0), 64'(1));
        chk("rdata_timing", 64'(ack_prev), 64'(1));
        if (exp_rd_q.size() != 0) begin
          m_d = exp_rd_q.pop_front();
          chk("rdata", 64'(rdata), 64'(m_d));
        end
      end
      if (done) begin
        $display("done cyc=%0d err=%0d", cyc, err);
        done_cnt++;
        chk("done_expected", 64'(exp_done_q.size() != 0), 64'(1));
        if (exp_done_q.size() != 0) begin
          m_err = exp_done_q.pop_front();
          chk("done_err", 64'(err), 64'(m_err));
          if (m_err) begin
            chk("timeout_latency", 64'(cyc - req_rise_cyc), 64'(TO + 1));
            chk("timeout_req_dropped", 64'({wr, rd, data_oe}), 64'(0));
          end else begin
            chk("done_latency", 64'(cyc - last_ack_cyc), 64'(GAP + 1));
          end
        end
        have_ack = 1'b0;
      end
      if (ack && req_now) begin
        last_ack_cyc = cyc;
        have_ack     = 1'b1;
      end
      ack_prev = ack && req_now;
      req_prev = req_now;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue the expected outcome of a burst, then present the command for one accept.
  task automatic send_cmd(input logic op, input logic [ADDR_W-1:0] a, input logic [3:0] len,
                          input logic expect_timeout);
    int   k;
    req_t e;
    k = 0;
    while (!cmd_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    for (int i = 0; i <= int'(len); i++) begin
      if (expect_timeout && i > 0) break;
      e.op   = op;
      e.addr = a + ADDR_W'(i);
      if (op == OP_WR) begin
        e.data = wbuf[i];
        shadow[e.addr] = e.data;
        wdata_q.push_back(e.data);
      end else begin
        e.data = shadow[e.addr];
        if (!expect_timeout) exp_rd_q.push_back(e.data);
      end
      exp_req_q.push_back(e);
    end
    exp_done_q.push_back(expect_timeout);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((exp_done_q.size() != 0 || !cmd_ready) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("burst_completes", 64'(exp_done_q.size()), 64'(0));
  endtask

  initial begin
    int rises0, dn0, k;
    for (int i = 0; i < 2048; i++) begin
      eeprom[i] = 8'(i * 13 + 7);
      shadow[i] = 8'(i * 13 + 7);
    end
    tick(3);
    chk("reset_outputs", 64'({cmd_ready, wdata_ready, rdata_valid, rdata, done, err, busy,
                              wr, rd, addr, data_out, data_oe}), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'({cmd_ready, busy}), 64'(2'b10));

    // Single write.
    ack_delay = 50;
    wbuf[0] = 8'hA5;
    send_cmd(OP_WR, 11'h123, 4'd0, 1'b0);
    wait_drain(1000);
    chk("eeprom_0x123", 64'(eeprom[11'h123]), 64'(8'hA5));

    // Read burst from preloaded bytes.
    eeprom[11'h010] = 8'h11; eeprom[11'h011] = 8'h22; eeprom[11'h012] = 8'h33; eeprom[11'h013] = 8'h44;
    shadow[11'h010] = 8'h11; shadow[11'h011] = 8'h22; shadow[11'h012] = 8'h33; shadow[11'h013] = 8'h44;
    ack_delay = 5;
    send_cmd(OP_RD, 11'h010, 4'd3, 1'b0);
    wait_drain(1000);

    // Address wrap on a write burst, then read it back.
    ack_delay = 3;
    wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03; wbuf[3] = 8'h04;
    send_cmd(OP_WR, 11'h7FE, 4'd3, 1'b0);
    wait_drain(1000);
    send_cmd(OP_RD, 11'h7FE, 4'd3, 1'b0);
    wait_drain(1000);

    // Timeout with ack never asserted, then a normal command.
    ack_en = 1'b0;
    send_cmd(OP_RD, 11'h200, 4'd2, 1'b1);
    wait_drain(TO + 200);
    ack_en = 1'b1;
    send_cmd(OP_RD, 11'h123, 4'd0, 1'b0);
    wait_drain(1000);

    // Stray ack while idle.
    stray_ack = 1'b1;
    tick(1);
    stray_ack = 1'b0;
    tick(2);
    chk("stray_ack_idle", 64'({cmd_ready, busy, done, wr, rd}), 64'(5'b10000));

    // Write starvation, then a stray ack inside the gap.
    wd_hold = 1'b1;
    wbuf[0] = 8'hC3; wbuf[1] = 8'h3C;
    rises0 = req_rises;
    dn0    = done_cnt;
    send_cmd(OP_WR, 11'h050, 4'd1, 1'b0);
    tick(500);
    chk("starve_no_wr", 64'(req_rises - rises0), 64'(0));
    chk("starve_no_done", 64'(done_cnt - dn0), 64'(0));
    chk("starve_in_fetch", 64'({busy, wdata_ready}), 64'(2'b11));
    wd_hold = 1'b0;
    k = 0;
    while (req_rises == rises0 && k < 200) begin @(negedge clk); k++; end
    k = 0;
    while ((wr || model_ack) && k < 200) begin @(negedge clk); k++; end
    tick(3);
    stray_ack = 1'b1;
    tick(1);
    stray_ack = 1'b0;
    wait_drain(1000);

    // Reset in the middle of WAIT_ACK.
    ack_en = 1'b0;
    send_cmd(OP_RD, 11'h300, 4'd1, 1'b0);
    k = 0;
    while (!rd && k < 50) begin @(negedge clk); k++; end
    tick(5);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("midreset_outputs", 64'({cmd_ready, wdata_ready, rdata_valid, rdata, done, err, busy,
                                    wr, rd, addr, data_out, data_oe}), 64'(0));
    exp_req_q.delete();
    exp_rd_q.delete();
    exp_done_q.delete();
    dn0 = done_cnt;
    @(negedge clk);
    reset  = 1'b0;
    ack_en = 1'b1;
    tick(20);
    chk("midreset_no_done", 64'(done_cnt - dn0), 64'(0));
    chk("midreset_ready", 64'({cmd_ready, busy}), 64'(2'b10));

    // Read back the starved write burst after recovery.
    send_cmd(OP_RD, 11'h050, 4'd1, 1'b0);
    wait_drain(1000);

    chk("queues_empty", 64'(exp_req_q.size() + exp_rd_q.size() + exp_done_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
